// File: rtl/holy_axi_arbiter_if.sv
// AXI4 bundle shared by the i-cache, d-cache and the core's external master port.
interface axi_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/holy_axi_arbiter.sv
// Shares one AXI master between i-cache (s0, read-only) and d-cache (s1), one burst per grant.
// Define HOLY_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise the d-cache wins ties.
module holy_axi_arbiter #(
    parameter logic [3:0] S0_ID = 4'h0,
    parameter logic [3:0] S1_ID = 4'h1
) (
    input  logic       clk,
    input  logic       rst,
    axi_if.slave       s0_axi,
    axi_if.slave       s1_axi,
    axi_if.master      m_axi,
    output logic [1:0] debug_arb_state,
    output logic       debug_arb_owner
);
    typedef enum logic [1:0] {IDLE = 2'b00, RD = 2'b01, WR = 2'b10} state_t;

    state_t state;
    logic   owner;
    logic   last;
    logic   req0, req1, grant;
    logic   rd_act, wr_act, rd0, rd1;

    assign req0 = s0_axi.arvalid;
    assign req1 = s1_axi.arvalid | s1_axi.awvalid;

    always_comb begin
        grant = req1;
`ifdef HOLY_ARB_ROUND_ROBIN_EN
        if (req0 && req1) grant = ~last;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    owner <= grant;
                    // A d-cache holding both AW and AR is served write-first
                    state <= (grant && s1_axi.awvalid) ? WR : RD;
                end
                RD: if (m_axi.rvalid && m_axi.rready && m_axi.rlast) begin
                    state <= IDLE;
                    last  <= owner;
                end
                WR: if (m_axi.bvalid && m_axi.bready) begin
                    state <= IDLE;
                    last  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign debug_arb_state = state;
    assign debug_arb_owner = owner;

    assign rd_act = (state == RD);
    assign wr_act = (state == WR);
    assign rd0    = rd_act & ~owner;
    assign rd1    = rd_act & owner;

    // Read address/data: owner's AR goes out with its fixed ID, R comes back to it
    assign m_axi.arid    = owner ? S1_ID : S0_ID;
    assign m_axi.araddr  = owner ? s1_axi.araddr  : s0_axi.araddr;
    assign m_axi.arlen   = owner ? s1_axi.arlen   : s0_axi.arlen;
    assign m_axi.arsize  = owner ? s1_axi.arsize  : s0_axi.arsize;
    assign m_axi.arburst = owner ? s1_axi.arburst : s0_axi.arburst;
    assign m_axi.arvalid = rd_act & (owner ? s1_axi.arvalid : s0_axi.arvalid);
    assign m_axi.rready  = rd_act & (owner ? s1_axi.rready  : s0_axi.rready);

    assign s0_axi.arready = rd0 & m_axi.arready;
    assign s0_axi.rvalid  = rd0 & m_axi.rvalid;
    assign s0_axi.rid     = m_axi.rid;
    assign s0_axi.rdata   = m_axi.rdata;
    assign s0_axi.rresp   = m_axi.rresp;
    assign s0_axi.rlast   = m_axi.rlast;

    assign s1_axi.arready = rd1 & m_axi.arready;
    assign s1_axi.rvalid  = rd1 & m_axi.rvalid;
    assign s1_axi.rid     = m_axi.rid;
    assign s1_axi.rdata   = m_axi.rdata;
    assign s1_axi.rresp   = m_axi.rresp;
    assign s1_axi.rlast   = m_axi.rlast;

    // Write path only ever belongs to the d-cache
    assign m_axi.awid    = S1_ID;
    assign m_axi.awaddr  = s1_axi.awaddr;
    assign m_axi.awlen   = s1_axi.awlen;
    assign m_axi.awsize  = s1_axi.awsize;
    assign m_axi.awburst = s1_axi.awburst;
    assign m_axi.awvalid = wr_act & s1_axi.awvalid;
    assign m_axi.wdata   = s1_axi.wdata;
    assign m_axi.wstrb   = s1_axi.wstrb;
    assign m_axi.wlast   = s1_axi.wlast;
    assign m_axi.wvalid  = wr_act & s1_axi.wvalid;
    assign m_axi.bready  = wr_act & s1_axi.bready;

    assign s1_axi.awready = wr_act & m_axi.awready;
    assign s1_axi.wready  = wr_act & m_axi.wready;
    assign s1_axi.bvalid  = wr_act & m_axi.bvalid;
    assign s1_axi.bid     = m_axi.bid;
    assign s1_axi.bresp   = m_axi.bresp;

    assign s0_axi.awready = 1'b0;
    assign s0_axi.wready  = 1'b0;
    assign s0_axi.bvalid  = 1'b0;
    assign s0_axi.bid     = 4'h0;
    assign s0_axi.bresp   = 2'b00;

    // Inputs with no function here: s0 write side, requester IDs, and last in fixed-priority builds
    logic unused_sigs;
    assign unused_sigs = ^{s0_axi.awid, s0_axi.awaddr, s0_axi.awlen, s0_axi.awsize,
                           s0_axi.awburst, s0_axi.awvalid, s0_axi.wdata, s0_axi.wstrb,
                           s0_axi.wlast, s0_axi.wvalid, s0_axi.bready, s0_axi.arid,
                           s1_axi.arid, s1_axi.awid, last};
endmodule

// File: tb/tb_holy_axi_arbiter.sv
// Directed bench for holy_axi_arbiter: grant table plus burst, isolation and reset sequences.
module tb_holy_axi_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    logic       dbg_owner;

    axi_if s0();
    axi_if s1();
    axi_if m();

    holy_axi_arbiter #(.S0_ID(4'h0), .S1_ID(4'h1)) dut (
        .clk(clk), .rst(rst), .s0_axi(s0), .s1_axi(s1), .m_axi(m),
        .debug_arb_state(dbg_state), .debug_arb_owner(dbg_owner)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       ar0, ar1, aw1;
        logic [1:0] st;
        logic       own, arv, awv;
        logic [3:0] id;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {s0.arid, s0.araddr, s0.arlen, s0.arsize, s0.arburst, s0.arvalid, s0.rready} = '0;
        {s0.awid, s0.awaddr, s0.awlen, s0.awsize, s0.awburst, s0.awvalid} = '0;
        {s0.wdata, s0.wstrb, s0.wlast, s0.wvalid, s0.bready} = '0;
        {s1.arid, s1.araddr, s1.arlen, s1.arsize, s1.arburst, s1.arvalid, s1.rready} = '0;
        {s1.awid, s1.awaddr, s1.awlen, s1.awsize, s1.awburst, s1.awvalid} = '0;
        {s1.wdata, s1.wstrb, s1.wlast, s1.wvalid, s1.bready} = '0;
        {m.arready, m.rid, m.rdata, m.rresp, m.rlast, m.rvalid} = '0;
        {m.awready, m.wready, m.bid, m.bresp, m.bvalid} = '0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [11:0] handshakes();
        return {m.arvalid, m.awvalid, m.wvalid, m.rready, m.bready, s0.arready,
                s0.rvalid, s1.arready, s1.awready, s1.wready, s1.rvalid, s1.bvalid};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required self-termination");
        $fatal(1);
    end

    initial begin
        int beats;
        logic exp_tie [3];

        // ar0 ar1 aw1 | state owner arvalid awvalid id
        vecs[0] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 4'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 4'h1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 4'h1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 4'h1};
`ifdef HOLY_ARB_ROUND_ROBIN_EN
        vecs[5] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 4'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 4'h0};
        exp_tie = '{1'b0, 1'b1, 1'b0};
`else
        vecs[5] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 4'h1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 4'h1};
        exp_tie = '{1'b1, 1'b1, 1'b1};
`endif

        // Reset values
        do_reset();
        chk("reset_state", 32'(dbg_state), 32'd0);
        chk("reset_owner", 32'(dbg_owner), 32'd0);
        chk("reset_handshakes", 32'(handshakes()), 32'd0);

        // Grant table: one decision from a fresh reset per vector
        for (int i = 0; i < 7; i++) begin
            do_reset();
            s0.arvalid = vecs[i].ar0;
            s1.arvalid = vecs[i].ar1;
            s1.awvalid = vecs[i].aw1;
            #1;
            chk($sformatf("v%0d_idle_gated", i), 32'(handshakes()), 32'd0);
            tick();
            chk($sformatf("v%0d_state", i), 32'(dbg_state), 32'(vecs[i].st));
            chk($sformatf("v%0d_owner", i), 32'(dbg_owner), 32'(vecs[i].own));
            chk($sformatf("v%0d_arvalid", i), 32'(m.arvalid), 32'(vecs[i].arv));
            chk($sformatf("v%0d_awvalid", i), 32'(m.awvalid), 32'(vecs[i].awv));
            if (vecs[i].st == 2'b01) chk($sformatf("v%0d_arid", i), 32'(m.arid), 32'(vecs[i].id));
            if (vecs[i].st == 2'b10) chk($sformatf("v%0d_awid", i), 32'(m.awid), 32'(vecs[i].id));
        end

        // Single i-cache read, 4 beats
        do_reset();
        s0.arvalid = 1'b1; s0.araddr = 32'h0000_0100; s0.arlen = 8'd3;
        m.arready = 1'b1;
        #1;
        chk("a_idle_arready", 32'(s0.arready), 32'd0);
        tick();
        chk("a_state_rd", 32'(dbg_state), 32'd1);
        chk("a_araddr", m.araddr, 32'h0000_0100);
        chk("a_arlen", 32'(m.arlen), 32'd3);
        chk("a_arid", 32'(m.arid), 32'd0);
        chk("a_arready", 32'(s0.arready), 32'd1);
        tick();
        s0.arvalid = 1'b0;
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            m.rvalid = 1'b1; m.rdata = 32'hA000 + 32'(i); m.rlast = (i == 3); s0.rready = 1'b1;
            #1;
            if (s0.rvalid && m.rready) beats++;
            chk($sformatf("a_rdata%0d", i), s0.rdata, 32'hA000 + 32'(i));
            chk($sformatf("a_s1_quiet%0d", i), 32'(s1.rvalid), 32'd0);
            tick();
        end
        chk("a_beats", 32'(beats), 32'd4);
        chk("a_state_idle", 32'(dbg_state), 32'd0);
        m.rlast = 1'b0;
        #1;
        chk("a_idle_rvalid_gated", 32'(s0.rvalid), 32'd0);

        // D-cache write then read
        do_reset();
        s1.awvalid = 1'b1; s1.awaddr = 32'h2000_0000; s1.awlen = 8'd7;
        s1.arvalid = 1'b1; s1.araddr = 32'h2000_0040;
        m.awready = 1'b1; m.wready = 1'b1; m.arready = 1'b1;
        tick();
        chk("b_state_wr", 32'(dbg_state), 32'd2);
        chk("b_owner", 32'(dbg_owner), 32'd1);
        chk("b_awid", 32'(m.awid), 32'd1);
        chk("b_awaddr", m.awaddr, 32'h2000_0000);
        chk("b_awlen", 32'(m.awlen), 32'd7);
        chk("b_ar_gated", 32'({m.arvalid, s1.arready}), 32'd0);
        tick();
        s1.awvalid = 1'b0;
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            s1.wvalid = 1'b1; s1.wdata = 32'hB000 + 32'(i); s1.wlast = (i == 7);
            #1;
            if (m.wvalid && m.wready && s1.wready) beats++;
            chk($sformatf("b_wdata%0d", i), m.wdata, 32'hB000 + 32'(i));
            tick();
        end
        s1.wvalid = 1'b0; s1.wlast = 1'b0;
        chk("b_wbeats", 32'(beats), 32'd8);
        m.bvalid = 1'b1; m.bresp = 2'b10; s1.bready = 1'b1;
        #1;
        chk("b_bvalid", 32'(s1.bvalid), 32'd1);
        chk("b_bresp", 32'(s1.bresp), 32'd2);
        chk("b_bready", 32'(m.bready), 32'd1);
        tick();
        m.bvalid = 1'b0;
        #1;
        chk("b_dead_state", 32'(dbg_state), 32'd0);
        chk("b_dead_arvalid", 32'(m.arvalid), 32'd0);
        tick();
        chk("b_rd_state", 32'(dbg_state), 32'd1);
        chk("b_rd_arid", 32'(m.arid), 32'd1);
        chk("b_rd_araddr", m.araddr, 32'h2000_0040);
        tick();
        s1.arvalid = 1'b0;
        m.rvalid = 1'b1; m.rlast = 1'b1; s1.rready = 1'b1;
        #1;
        chk("b_rvalid", 32'(s1.rvalid), 32'd1);
        tick();
        chk("b_end_idle", 32'(dbg_state), 32'd0);

        // Simultaneous reads after reset: grant order
        do_reset();
        s0.arvalid = 1'b1; s1.arvalid = 1'b1; s0.rready = 1'b1; s1.rready = 1'b1;
        m.arready = 1'b1; m.rvalid = 1'b1; m.rlast = 1'b1;
        for (int g = 0; g < 3; g++) begin
            tick();
            chk($sformatf("c_grant%0d_state", g), 32'(dbg_state), 32'd1);
            chk($sformatf("c_grant%0d_owner", g), 32'(dbg_owner), 32'(exp_tie[g]));
            tick();
            chk($sformatf("c_turn%0d_state", g), 32'(dbg_state), 32'd0);
        end

        // Isolation: s1 waits while s0 bursts
        do_reset();
        s0.arvalid = 1'b1; s0.arlen = 8'd3; m.arready = 1'b1;
        tick();
        s1.arvalid = 1'b1;
        #1;
        chk("d_s1_arready", 32'(s1.arready), 32'd0);
        tick();
        s0.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m.rvalid = 1'b1; m.rlast = (i == 3); s0.rready = 1'b1; s1.rready = 1'b1;
            #1;
            chk($sformatf("d_iso%0d", i), 32'({s1.arready, s1.rvalid, dbg_owner}), 32'd0);
            tick();
        end
        m.rvalid = 1'b0; m.rlast = 1'b0;
        #1;
        chk("d_dead", 32'({dbg_state, s1.arready}), 32'd0);
        tick();
        chk("d_s1_granted", 32'({dbg_state, dbg_owner}), 32'b011);
        chk("d_s1_arid", 32'(m.arid), 32'd1);

        // Reset mid-burst, then a fresh read
        do_reset();
        s0.arvalid = 1'b1; s0.arlen = 8'd3; m.arready = 1'b1;
        tick();
        tick();
        s0.arvalid = 1'b0;
        m.rvalid = 1'b1; s0.rready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("e_state", 32'(dbg_state), 32'd0);
        chk("e_owner", 32'(dbg_owner), 32'd0);
        chk("e_gated", 32'(handshakes()), 32'd0);
        m.rvalid = 1'b0;
        s0.arvalid = 1'b1; s0.arlen = 8'd0;
        tick();
        chk("e_regrant", 32'({dbg_state, dbg_owner}), 32'b010);
        tick();
        s0.arvalid = 1'b0;
        m.rvalid = 1'b1; m.rlast = 1'b1;
        #1;
        chk("e_rvalid", 32'(s0.rvalid), 32'd1);
        tick();
        chk("e_done", 32'(dbg_state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
